pc_sequencer: RTL and testbench

- Program-counter and call/return sequencer for the CPU.
- Sits directly upstream of the return-address stack: drives its opcode and push data, and consumes its registered pop output on RET.
- Handles sequential fetch, JMP, CALL and RET.
- Tracks stack depth locally and flags overflow/underflow instead of corrupting the PC.

---
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter and call/return sequencer. It drives the return-address stack
// and traps stack overflow/underflow into a sticky fault and a HALT state.
module pc_sequencer #(
  parameter int          ADDR_W    = 12,
  parameter int          DEPTH     = 12,
  parameter logic [11:0] RESET_PC  = 12'h000,
  parameter logic [3:0]  OP_NOP    = 4'h0,
  parameter logic [3:0]  OP_PUSH_R = 4'h6,
  parameter logic [3:0]  OP_POP_R  = 4'h7,
  parameter logic [3:0]  OP_JMP    = 4'h8,
  parameter logic [3:0]  OP_CALL   = 4'h9,
  parameter logic [3:0]  OP_RET    = 4'hA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] stk_pop,
  output logic [3:0]        stk_op,
  output logic [ADDR_W-1:0] stk_push,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fault
);

  localparam int DEPTH_W = $clog2(DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_WAIT_POP = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                fault_q, fault_d;
  logic [ADDR_W-1:0]   pc_inc;

  assign pc_inc = pc_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= ADDR_W'(RESET_PC);
      depth_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    depth_d  = depth_q;
    fault_d  = fault_q;
    stk_op   = OP_NOP;
    stk_push = '0;
    unique case (state_q)
      S_RUN: begin
        if (en) begin
          case (opcode)
            OP_JMP: pc_d = target;
            OP_CALL: begin
              if (depth_q != DEPTH_MAX) begin
                stk_op   = OP_PUSH_R;
                stk_push = pc_inc;
                pc_d     = target;
                depth_d  = depth_q + 1'b1;
              end else begin
                fault_d = 1'b1;
                state_d = S_HALT;
              end
            end
            OP_RET: begin
              if (depth_q != '0) begin
                stk_op  = OP_POP_R;
                depth_d = depth_q - 1'b1;
                state_d = S_WAIT_POP;
              end else begin
                fault_d = 1'b1;
                state_d = S_HALT;
              end
            end
            default: pc_d = pc_inc;
          endcase
        end
      end
      // The stack's registered pop data is valid in this cycle only.
      S_WAIT_POP: begin
        pc_d    = stk_pop;
        state_d = S_RUN;
      end
      S_HALT: fault_d = 1'b1;
      default: begin
        fault_d = 1'b1;
        state_d = S_HALT;
      end
    endcase
  end

  assign pc    = pc_q;
  assign busy  = (state_q == S_WAIT_POP);
  assign fault = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table-driven vectors plus overflow sequences,
// with a behavioural return-address stack and a scoreboard for registered outputs.
module tb_pc_sequencer;

  localparam int ADDR_W = 12;
  localparam logic [3:0] NOP = 4'h0, PUSH = 4'h6, POP = 4'h7;
  localparam logic [3:0] JMP = 4'h8, CALL = 4'h9, RET = 4'hA, PLAIN = 4'h1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [3:0]        opcode = 4'h0;
  logic [ADDR_W-1:0] target = '0;
  logic [ADDR_W-1:0] stk_pop;
  logic [3:0]        stk_op;
  logic [ADDR_W-1:0] stk_push;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fault;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .opcode(opcode), .target(target),
    .stk_pop(stk_pop), .stk_op(stk_op), .stk_push(stk_push),
    .pc(pc), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // Return-address stack model with a registered pop output.
  logic [ADDR_W-1:0] mem [0:15];
  int sp;
  always @(posedge clk) begin
    if (reset) begin
      sp      <= 0;
      stk_pop <= 12'hBAD;
    end else if (stk_op == PUSH) begin
      mem[sp] <= stk_push;
      sp      <= sp + 1;
    end else if (stk_op == POP && sp > 0) begin
      stk_pop <= mem[sp-1];
      sp      <= sp - 1;
    end
  end

  typedef struct {
    logic              rst;
    logic              en;
    logic [3:0]        op;
    logic [ADDR_W-1:0] tgt;
    logic              chk_comb;
    logic [3:0]        e_op;
    logic [ADDR_W-1:0] e_push;
    logic [ADDR_W-1:0] e_pc;
    logic              e_busy;
    logic              e_fault;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              fault;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic rst, input logic e, input logic [3:0] op,
                              input logic [11:0] tgt, input logic cc, input logic [3:0] eop,
                              input logic [11:0] epush, input logic [11:0] epc,
                              input logic eb, input logic ef);
    vec_t v;
    v.rst = rst; v.en = e; v.op = op; v.tgt = tgt; v.chk_comb = cc;
    v.e_op = eop; v.e_push = epush; v.e_pc = epc; v.e_busy = eb; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: combinational outputs checked before the edge, registered
  // expectations queued and compared just after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset = v.rst; en = v.en; opcode = v.op; target = v.tgt;
    #1;
    if (v.chk_comb) begin
      chk("stk_op", {28'd0, stk_op}, {28'd0, v.e_op});
      chk("stk_push", {20'd0, stk_push}, {20'd0, v.e_push});
    end
    e.pc = v.e_pc; e.busy = v.e_busy; e.fault = v.e_fault;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("pc", {20'd0, pc}, {20'd0, e.pc});
      chk("busy", {31'd0, busy}, {31'd0, e.busy});
      chk("fault", {31'd0, fault}, {31'd0, e.fault});
    end
  endtask

  task automatic do_reset();
    apply(mk(1, 0, NOP, 0, 0, NOP, 0, 0, 0, 0));
  endtask

  initial begin
    logic [ADDR_W-1:0] cur_pc;
    logic [ADDR_W-1:0] ret_stack[$];
    logic [ADDR_W-1:0] t;

    //     rst en op     tgt      cc eop   epush    epc     eb ef
    tbl.push_back(mk(1, 0, NOP,   0,      0, NOP,  0,       0,      0, 0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0, 1, PLAIN, 0,    1, NOP,  0,       12'(i), 0, 0));
    tbl.push_back(mk(0, 1, CALL,  12'h100, 1, PUSH, 12'h006, 12'h100, 0, 0));
    tbl.push_back(mk(0, 1, RET,   0,      1, POP,  0,       12'h100, 1, 0));
    tbl.push_back(mk(0, 1, JMP,   12'h777, 1, NOP, 0,       12'h006, 0, 0));
    tbl.push_back(mk(0, 1, JMP,   12'h010, 1, NOP, 0,       12'h010, 0, 0));
    tbl.push_back(mk(0, 1, CALL,  12'h200, 1, PUSH, 12'h011, 12'h200, 0, 0));
    tbl.push_back(mk(0, 1, CALL,  12'h300, 1, PUSH, 12'h201, 12'h300, 0, 0));
    tbl.push_back(mk(0, 1, RET,   0,      1, POP,  0,       12'h300, 1, 0));
    tbl.push_back(mk(0, 0, NOP,   0,      1, NOP,  0,       12'h201, 0, 0));
    tbl.push_back(mk(0, 1, RET,   0,      1, POP,  0,       12'h201, 1, 0));
    tbl.push_back(mk(0, 0, NOP,   0,      1, NOP,  0,       12'h011, 0, 0));
    // depth is back to 0: another RET underflows
    tbl.push_back(mk(0, 1, RET,   0,      1, NOP,  0,       12'h011, 0, 1));
    tbl.push_back(mk(0, 1, JMP,   12'h055, 1, NOP, 0,       12'h011, 0, 1));
    tbl.push_back(mk(1, 0, NOP,   0,      0, NOP,  0,       0,      0, 0));
    tbl.push_back(mk(0, 1, RET,   0,      1, NOP,  0,       0,      0, 1));
    tbl.push_back(mk(0, 1, PLAIN, 0,      1, NOP,  0,       0,      0, 1));
    tbl.push_back(mk(1, 0, NOP,   0,      0, NOP,  0,       0,      0, 0));
    // wrap and en=0 hold
    tbl.push_back(mk(0, 1, JMP,   12'hFFF, 1, NOP, 0,       12'hFFF, 0, 0));
    tbl.push_back(mk(0, 0, CALL,  12'h123, 1, NOP, 0,       12'hFFF, 0, 0));
    tbl.push_back(mk(0, 1, CALL,  12'h123, 1, PUSH, 12'h000, 12'h123, 0, 0));
    tbl.push_back(mk(0, 1, PLAIN, 0,      1, NOP,  0,       12'h124, 0, 0));
    tbl.push_back(mk(0, 1, JMP,   12'hFFF, 1, NOP, 0,       12'hFFF, 0, 0));
    tbl.push_back(mk(0, 1, PLAIN, 0,      1, NOP,  0,       12'h000, 0, 0));
    // reset in the WAIT_POP cycle: pop discarded, depth cleared
    tbl.push_back(mk(0, 1, RET,   0,      1, POP,  0,       12'h000, 1, 0));
    tbl.push_back(mk(1, 1, PLAIN, 0,      0, NOP,  0,       0,      0, 0));
    tbl.push_back(mk(0, 1, RET,   0,      1, NOP,  0,       0,      0, 1));
    tbl.push_back(mk(1, 0, NOP,   0,      0, NOP,  0,       0,      0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Fill to capacity, unwind fully, refill, then overflow.
    for (int pass = 0; pass < 2; pass++) begin
      cur_pc = 12'h000;
      for (int i = 0; i < 12; i++) begin
        t = 12'h400 + 12'(i * 16) + 12'(pass);
        apply(mk(0, 1, CALL, t, 1, PUSH, cur_pc + 12'd1, t, 0, 0));
        ret_stack.push_back(cur_pc + 12'd1);
        cur_pc = t;
      end
      if (pass == 0) begin
        for (int i = 0; i < 12; i++) begin
          apply(mk(0, 1, RET, 0, 1, POP, 0, cur_pc, 1, 0));
          cur_pc = ret_stack.pop_back();
          apply(mk(0, 1, PLAIN, 0, 1, NOP, 0, cur_pc, 0, 0));
        end
        apply(mk(0, 1, RET, 0, 1, NOP, 0, cur_pc, 0, 1));
        do_reset();
      end
    end
    apply(mk(0, 1, CALL, 12'hABC, 1, NOP, 0, cur_pc, 0, 1));
    apply(mk(0, 1, RET,   0,       1, NOP, 0, cur_pc, 0, 1));
    apply(mk(0, 1, PLAIN, 0,       1, NOP, 0, cur_pc, 0, 1));
    apply(mk(0, 1, JMP,   12'h001, 1, NOP, 0, cur_pc, 0, 1));
    do_reset();
    apply(mk(0, 1, PLAIN, 0, 1, NOP, 0, 12'h001, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
